// File: rtl/tt_sweep_checker.sv
// rtl/tt_sweep_checker.sv - exhaustive truth-table sweep checker for a small combinational DUT
// Drives every stim value in ascending order, captures resp, and counts mismatches against EXP_TT.
module tt_sweep_checker #(
  parameter int                   N_IN   = 3,
  parameter logic [(1<<N_IN)-1:0] EXP_TT = 'h31,
  parameter int                   SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [N_IN-1:0]        stim,
  input  logic                   resp,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        first_fail,
  output logic [(1<<N_IN)-1:0]   captured
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};
  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

  state_t                 state_q, state_d;
  logic [N_IN-1:0]        idx_q, idx_d;
  logic [3:0]             wait_q, wait_d;
  logic [N_IN-1:0]        stim_q, stim_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [N_IN:0]          err_q, err_d;
  logic [N_IN-1:0]        ff_q, ff_d;
  logic [(1<<N_IN)-1:0]   capt_q, capt_d;
  logic                   accept;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    capt_d  = capt_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: accept = start;
      APPLY: begin
        stim_d = idx_q;
        if (wait_q == SETTLE_C) begin
          wait_d  = 4'd0;
          state_d = SAMPLE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      SAMPLE: begin
        capt_d[idx_q] = resp;
        if (resp != EXP_TT[idx_q]) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) ff_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = APPLY;
        end
      end
      DONE: begin
        // First DONE cycle publishes the final results; start is taken only once done is visible.
        if (!done_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          pass_d = (err_q == '0);
        end else begin
          accept = start;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = APPLY;
      idx_d   = '0;
      wait_d  = 4'd0;
      stim_d  = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      err_d   = '0;
      ff_d    = '0;
      capt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= 4'd0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      capt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      capt_q  <= capt_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign captured   = capt_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb/tb_tt_sweep_checker.sv - directed table-driven bench for tt_sweep_checker
// Instance 0 uses default parameters, instance 1 uses SETTLE=0.
module tb_tt_sweep_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_r [2];
  logic [2:0] mode_r  [2];
  logic       resp_w  [2];
  logic [2:0] stim_w  [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic       pass_w  [2];
  logic [3:0] err_w   [2];
  logic [2:0] ff_w    [2];
  logic [7:0] capt_w  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // mode 0 golden sillyfunction, 1 tied 0, 2 inverted, 3 tied 1, 4 follows input a
  function automatic logic model(input logic [2:0] m, input logic [2:0] s);
    logic a, b, c, y;
    a = s[2];
    b = s[1];
    c = s[0];
    y = (~b & ~c) | (a & ~b);
    case (m)
      3'd0:    return y;
      3'd1:    return 1'b0;
      3'd2:    return ~y;
      3'd3:    return 1'b1;
      default: return a;
    endcase
  endfunction

  assign resp_w[0] = model(mode_r[0], stim_w[0]);
  assign resp_w[1] = model(mode_r[1], stim_w[1]);

  tt_sweep_checker u_dut (
    .clk(clk), .reset(reset), .start(start_r[0]), .stim(stim_w[0]), .resp(resp_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]),
    .first_fail(ff_w[0]), .captured(capt_w[0])
  );

  tt_sweep_checker #(.N_IN(3), .EXP_TT(8'h31), .SETTLE(0)) u_dut_s0 (
    .clk(clk), .reset(reset), .start(start_r[1]), .stim(stim_w[1]), .resp(resp_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]),
    .first_fail(ff_w[1]), .captured(capt_w[1])
  );

  typedef struct {
    string      name;
    logic [2:0] mode;
    logic [3:0] err;
    logic [2:0] ff;
    logic [7:0] capt;
    logic       pass;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input int s, input string tag);
    chk({tag, "_stim"}, int'(stim_w[s]), 0);
    chk({tag, "_busy"}, int'(busy_w[s]), 0);
    chk({tag, "_done"}, int'(done_w[s]), 0);
    chk({tag, "_pass"}, int'(pass_w[s]), 0);
    chk({tag, "_err"},  int'(err_w[s]),  0);
    chk({tag, "_ff"},   int'(ff_w[s]),   0);
    chk({tag, "_capt"}, int'(capt_w[s]), 0);
  endtask

  task automatic check_results(input int s, input vec_t v);
    chk({v.name, "_done"}, int'(done_w[s]), 1);
    chk({v.name, "_busy"}, int'(busy_w[s]), 0);
    chk({v.name, "_pass"}, int'(pass_w[s]), int'(v.pass));
    chk({v.name, "_err"},  int'(err_w[s]),  int'(v.err));
    chk({v.name, "_ff"},   int'(ff_w[s]),   int'(v.ff));
    chk({v.name, "_capt"}, int'(capt_w[s]), int'(v.capt));
  endtask

  // Pulses start, then follows the sweep edge by edge; restart_stim >= 0 pulses start again mid-sweep.
  task automatic run_sweep(input int s, input logic [2:0] mode, input int restart_stim, input string tag);
    int settle, exp_lat, j, exp_stim;
    logic stim_ok, pulsed;
    settle  = (s == 0) ? 1 : 0;
    exp_lat = (settle + 2) * 8 + 1;
    mode_r[s] = mode;
    @(posedge clk); #1;
    start_r[s] = 1'b1;
    @(posedge clk); #1;
    start_r[s] = 1'b0;
    chk({tag, "_acc_busy"}, int'(busy_w[s]), 1);
    chk({tag, "_acc_done"}, int'(done_w[s]), 0);
    chk({tag, "_acc_err"},  int'(err_w[s]),  0);
    chk({tag, "_acc_capt"}, int'(capt_w[s]), 0);
    stim_ok = (stim_w[s] == 3'd0);
    pulsed  = 1'b0;
    j = 0;
    while (!done_w[s] && j < 200) begin
      if (restart_stim >= 0 && !pulsed && int'(stim_w[s]) == restart_stim) begin
        start_r[s] = 1'b1;
        pulsed = 1'b1;
      end
      @(posedge clk); #1;
      start_r[s] = 1'b0;
      j++;
      exp_stim = (j - 1) / (settle + 2);
      if (exp_stim > 7) exp_stim = 7;
      if (int'(stim_w[s]) != exp_stim) stim_ok = 1'b0;
    end
    chk({tag, "_latency"}, j, exp_lat);
    chk({tag, "_stim_steps"}, int'(stim_ok), 1);
  endtask

  initial begin
    vec_t golden;
    int   n;
    tbl[0] = '{"golden",   3'd0, 4'd0, 3'd0, 8'h31, 1'b1};
    tbl[1] = '{"tied0",    3'd1, 4'd3, 3'd0, 8'h00, 1'b0};
    tbl[2] = '{"inverted", 3'd2, 4'd8, 3'd0, 8'hCE, 1'b0};
    tbl[3] = '{"tied1",    3'd3, 4'd5, 3'd1, 8'hFF, 1'b0};
    tbl[4] = '{"follow_a", 3'd4, 4'd3, 3'd0, 8'hF0, 1'b0};
    golden = tbl[0];

    reset = 1'b1;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    mode_r[0] = 3'd0;
    mode_r[1] = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle(0, "rst0");
    check_idle(1, "rst1");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_sweep(0, tbl[i].mode, -1, tbl[i].name);
      check_results(0, tbl[i]);
    end

    // Results must hold in DONE without a new start.
    repeat (8) @(posedge clk);
    #1;
    chk("done_hold", int'(done_w[0]), 1);
    chk("capt_hold", int'(capt_w[0]), int'(tbl[4].capt));

    run_sweep(0, 3'd0, 3, "restart_ignored");
    golden.name = "restart_res";
    check_results(0, golden);

    // Reset at vector 5 aborts the sweep.
    mode_r[0] = 3'd0;
    @(posedge clk); #1;
    start_r[0] = 1'b1;
    @(posedge clk); #1;
    start_r[0] = 1'b0;
    n = 0;
    while (stim_w[0] != 3'd5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_vec5", int'(n < 100), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle(0, "midrst");
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_stays_idle", int'(busy_w[0]), 0);
    run_sweep(0, 3'd0, -1, "post_rst");
    golden.name = "post_rst_res";
    check_results(0, golden);

    // SETTLE=0 instance: failing sweep, then a restart from DONE.
    run_sweep(1, 3'd1, -1, "s0_tied0");
    tbl[1].name = "s0_tied0_res";
    check_results(1, tbl[1]);
    run_sweep(1, 3'd0, -1, "s0_golden");
    golden.name = "s0_golden_res";
    check_results(1, golden);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
